// File: rtl/rmt_phv_pkg.sv
// rmt_phv_pkg: shared PHV layout constants and container slice helpers
package rmt_phv_pkg;
  localparam int W2 = 16;
  localparam int W4 = 32;
  localparam int W6 = 48;
  localparam int N_CONT = 8;
  localparam int REMAIN_W = 256;
  localparam int OFF_2B = REMAIN_W;
  localparam int OFF_4B = OFF_2B + N_CONT * W2;
  localparam int OFF_6B = OFF_4B + N_CONT * W4;
  localparam int PHV_LEN = OFF_6B + N_CONT * W6;
  function automatic logic [W6-1:0] cont_6b(input logic [N_CONT*W6-1:0] bank, input int unsigned i);
    return bank[i*W6 +: W6];
  endfunction
  function automatic logic [W4-1:0] cont_4b(input logic [N_CONT*W4-1:0] bank, input int unsigned i);
    return bank[i*W4 +: W4];
  endfunction
  function automatic logic [W2-1:0] cont_2b(input logic [N_CONT*W2-1:0] bank, input int unsigned i);
    return bank[i*W2 +: W2];
  endfunction
endpackage

// File: rtl/phv_skid_buf2.sv
// phv_skid_buf2: 2-entry skid buffer with registered upstream ready
module phv_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready
);
  logic [W-1:0] head, tail, head_nx, tail_nx;
  logic [1:0] cnt, cnt_nx;
  logic push, pop;
  always_comb begin
    push = up_valid && up_ready;
    pop = dn_valid && dn_ready;
    cnt_nx = cnt + 2'(push) - 2'(pop);
    head_nx = (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) ? up_data :
              (pop && cnt == 2'd2) ? tail : head;
    tail_nx = (push && !pop && cnt == 2'd1) ? up_data : tail;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      up_ready <= 1'b1;
      dn_valid <= 1'b0;
    end else begin
      head <= head_nx;
      tail <= tail_nx;
      cnt <= cnt_nx;
      up_ready <= cnt_nx != 2'd2;
      dn_valid <= cnt_nx != 2'd0;
    end
  end
  assign dn_data = head;
endmodule

// File: rtl/phv_packer.sv
// phv_packer: repacks ALU container results into a PHV behind a skid buffer, with stats
module phv_packer #(
  parameter int STAGE_ID = 0,
  parameter int PHV_LEN = rmt_phv_pkg::PHV_LEN,
  parameter int width_2B = rmt_phv_pkg::W2,
  parameter int width_4B = rmt_phv_pkg::W4,
  parameter int width_6B = rmt_phv_pkg::W6,
  parameter int CNT_W = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alu_out_valid,
  input  logic [width_6B*8-1:0]             alu_out_6B,
  input  logic [width_4B*8-1:0]             alu_out_4B,
  input  logic [width_2B*8-1:0]             alu_out_2B,
  input  logic [rmt_phv_pkg::REMAIN_W-1:0]  phv_remain_data,
  output logic                              ready_out,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_out_valid,
  input  logic                              ready_in,
  output logic [CNT_W-1:0]                  phv_out_cnt,
  output logic [CNT_W-1:0]                  stall_cnt,
  output logic                              err_overflow
);
  import rmt_phv_pkg::*;
  if (STAGE_ID < 0 || PHV_LEN != N_CONT * (width_6B + width_4B + width_2B) + REMAIN_W) begin : g_bad_cfg
    $error("phv_packer: inconsistent PHV layout parameters");
  end
  phv_skid_buf2 #(.W(PHV_LEN)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (alu_out_valid),
    .up_data  ({alu_out_6B, alu_out_4B, alu_out_2B, phv_remain_data}),
    .up_ready (ready_out),
    .dn_valid (phv_out_valid),
    .dn_data  (phv_out),
    .dn_ready (ready_in)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phv_out_cnt <= '0;
      stall_cnt <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (phv_out_valid && ready_in) phv_out_cnt <= phv_out_cnt + CNT_W'(1);
      if (phv_out_valid && !ready_in && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (alu_out_valid && !ready_out) err_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_phv_packer.sv
// tb_phv_packer: directed stimulus checked every cycle against a queue model of the packer
module tb_phv_packer;
  import rmt_phv_pkg::*;
  localparam int CW = 8;
  logic clk = 0, rst_n = 0, alu_out_valid = 0, ready_in = 0;
  logic [N_CONT*W6-1:0] alu_out_6B = '0;
  logic [N_CONT*W4-1:0] alu_out_4B = '0;
  logic [N_CONT*W2-1:0] alu_out_2B = '0;
  logic [REMAIN_W-1:0] phv_remain_data = '0;
  logic ready_out, phv_out_valid, err_overflow;
  logic [PHV_LEN-1:0] phv_out;
  logic [CW-1:0] phv_out_cnt, stall_cnt;
  int n_assert = 0, n_fail = 0;
  bit chk_en = 0;
  logic [PHV_LEN-1:0] q[$];
  logic [CW-1:0] m_cnt = '0, m_stall = '0;
  logic m_err = 0;

  always #5 clk = ~clk;

  phv_packer #(.STAGE_ID(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .alu_out_valid(alu_out_valid),
    .alu_out_6B(alu_out_6B), .alu_out_4B(alu_out_4B), .alu_out_2B(alu_out_2B),
    .phv_remain_data(phv_remain_data), .ready_out(ready_out), .phv_out(phv_out),
    .phv_out_valid(phv_out_valid), .ready_in(ready_in), .phv_out_cnt(phv_out_cnt),
    .stall_cnt(stall_cnt), .err_overflow(err_overflow)
  );

  task automatic chk(input string name, input logic [PHV_LEN-1:0] act, input logic [PHV_LEN-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] tag);
    alu_out_6B = {8{16'h6B00, tag}};
    alu_out_4B = {8{tag ^ 32'h4B4B_0000}};
    alu_out_2B = {8{tag[15:0]}};
    phv_remain_data = 256'(tag);
    alu_out_valid = 1;
  endtask

  // Model: a FIFO of capacity two holding whole packed PHVs.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = '0;
      m_stall = '0;
      m_err = 0;
    end else begin
      automatic bit do_push = alu_out_valid && q.size() < 2;
      automatic bit do_pop = q.size() != 0 && ready_in;
      if (alu_out_valid && q.size() == 2) m_err = 1;
      if (q.size() != 0 && !ready_in && m_stall != 8'hFF) m_stall = m_stall + 1;
      if (do_pop) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 1;
      end
      if (do_push) q.push_back({alu_out_6B, alu_out_4B, alu_out_2B, phv_remain_data});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", phv_out_valid, q.size() != 0);
      chk("ready_out", ready_out, q.size() != 2);
      chk("phv_out_cnt", phv_out_cnt, m_cnt);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("err_overflow", err_overflow, m_err);
      if (q.size() != 0) begin
        chk("phv_out", phv_out, q[0]);
        chk("no_dead", phv_out[255:0] == 256'hDEAD, 0);
      end
    end
  end

  initial begin
    step();
    step();
    chk_en = 1;
    chk("rst_valid", phv_out_valid, 0);
    chk("rst_ready", ready_out, 1);
    chk("rst_phv", phv_out, 0);
    rst_n = 1;
    alu_out_6B = {8{48'h7}};
    alu_out_4B = {8{32'hA5A5_0001}};
    alu_out_2B = {8{16'hBEEF}};
    phv_remain_data = 256'h1;
    ready_in = 1;
    alu_out_valid = 1;
    step();
    alu_out_valid = 0;
    chk("pt_valid", phv_out_valid, 1);
    chk("pt_6b7", phv_out[1023:976], 48'h7);
    chk("pt_2b7", phv_out[383:368], 16'hBEEF);
    chk("pt_2b0", cont_2b(phv_out[OFF_4B-1:OFF_2B], 0), 16'hBEEF);
    chk("pt_4b3", cont_4b(phv_out[OFF_6B-1:OFF_4B], 3), 32'hA5A5_0001);
    chk("pt_6b0", cont_6b(phv_out[PHV_LEN-1:OFF_6B], 0), 48'h7);
    chk("pt_rem", phv_out[255:0], 1);
    step();
    chk("pt_cnt", phv_out_cnt, 1);
    chk("pt_empty", phv_out_valid, 0);
    ready_in = 0;
    beat('hA0);
    step();
    beat('hB0);
    step();
    alu_out_valid = 0;
    chk("bp_ready_low", ready_out, 0);
    chk("bp_head_a", phv_out[255:0], 'hA0);
    repeat (3) step();
    chk("bp_stall4", stall_cnt, 4);
    chk("bp_hold_a", phv_out[255:0], 'hA0);
    beat('hDEAD);
    step();
    alu_out_valid = 0;
    chk("ovf_err", err_overflow, 1);
    chk("ovf_stall5", stall_cnt, 5);
    chk("ovf_head_a", phv_out[255:0], 'hA0);
    step();
    chk("ovf_sticky", err_overflow, 1);
    chk("ovf_full", ready_out, 0);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mr_valid", phv_out_valid, 0);
    chk("mr_ready", ready_out, 1);
    chk("mr_cnt", phv_out_cnt, 0);
    chk("mr_stall", stall_cnt, 0);
    chk("mr_err", err_overflow, 0);
    ready_in = 1;
    beat('h55);
    step();
    alu_out_valid = 0;
    chk("mr_lat_valid", phv_out_valid, 1);
    chk("mr_lat_data", phv_out[255:0], 'h55);
    step();
    ready_in = 0;
    beat('hA2);
    step();
    beat('hB2);
    step();
    alu_out_valid = 0;
    chk("rl_full", ready_out, 0);
    chk("rl_head", phv_out[255:0], 'hA2);
    ready_in = 1;
    step();
    chk("rl_ready_back", ready_out, 1);
    chk("rl_next_b", phv_out[255:0], 'hB2);
    step();
    chk("rl_empty", phv_out_valid, 0);
    for (int i = 0; i < 100; i++) begin
      beat(1000 + i);
      step();
      chk("st_valid", phv_out_valid, 1);
      chk("st_order", phv_out[255:0], 1000 + i);
    end
    alu_out_valid = 0;
    step();
    chk("st_cnt103", phv_out_cnt, 103);
    ready_in = 0;
    beat('h77);
    step();
    alu_out_valid = 0;
    repeat (260) step();
    chk("lim_stall_sat", stall_cnt, 8'hFF);
    ready_in = 1;
    step();
    chk("lim_cnt104", phv_out_cnt, 104);
    for (int i = 0; i < 151; i++) begin
      beat(5000 + i);
      step();
    end
    alu_out_valid = 0;
    step();
    chk("lim_cnt_max", phv_out_cnt, 8'hFF);
    beat('h99);
    step();
    alu_out_valid = 0;
    step();
    chk("lim_cnt_wrap", phv_out_cnt, 0);
    ready_in = 0;
    beat('h98);
    step();
    alu_out_valid = 0;
    step();
    chk("lim_stall_hold", stall_cnt, 8'hFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/phv_packer.md
Name: phv_packer

Overview:
- Return path of an RMT action stage.
- Collects the per-container ALU results (6B, 4B and 2B banks) plus the untouched metadata/conditional tail, and repacks them into a full PHV for the next stage.
- Decouples the ALU pipeline from the downstream stage through a 2-entry skid buffer with a registered ready.
- Keeps emitted-PHV and stall statistics and a sticky protocol-error flag.

Parameters:
- STAGE_ID, 0, stage index; informational only, no effect on logic.
- PHV_LEN, 48*8+32*8+16*8+256 (1024), packed PHV width.
- width_2B, 16, 2-byte container width.
- width_4B, 32, 4-byte container width.
- width_6B, 48, 6-byte container width.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  stage clock.
- rst_n  in  1  reset, synchronous, active-low.
- alu_out_valid  in  1  ALU result beat valid.
- alu_out_6B  in  width_6B*8  6B results; container i at [(i+1)*width_6B-1 -: width_6B].
- alu_out_4B  in  width_4B*8  4B results, same indexing.
- alu_out_2B  in  width_2B*8  2B results, same indexing.
- phv_remain_data  in  256  metadata/conditional tail, passed through unmodified.
- ready_out  out  1  registered; upstream may present a beat only while high.
- phv_out  out  PHV_LEN  packed PHV.
- phv_out_valid  out  1  phv_out holds a valid beat.
- ready_in  in  1  downstream accept.
- phv_out_cnt  out  CNT_W  PHVs emitted; wraps.
- stall_cnt  out  CNT_W  cycles with phv_out_valid && !ready_in; saturates at all-ones.
- err_overflow  out  1  sticky flag; set by a beat presented while ready_out=0.

Behaviour:
- Packing: entry = {alu_out_6B, alu_out_4B, alu_out_2B, phv_remain_data}.
  - 6B container 7 lands at phv_out[PHV_LEN-1 -: 48].
  - 2B container 0 lands immediately above bit 255.
  - phv_out[255:0] = phv_remain_data.
  - No arithmetic or reordering.
- Storage: 2 entries (head, tail) and a 2-bit occupancy count, range 0..2.
- Push = alu_out_valid && ready_out. Pop = phv_out_valid && ready_in.
- phv_out_valid = (count != 0). phv_out = head entry; both are driven from registers.
- Latency: a beat pushed at cycle N appears on phv_out with phv_out_valid=1 at cycle N+1 when count was 0.
- Output stability: while phv_out_valid=1 and ready_in=0, phv_out is held stable.
- ready_out next = (count_next != 2). This guarantees one push can never overflow.
- Transitions:
  - count 0, push: store to head, count 1.
  - count 1, push only: store to tail, count 2.
  - count 1, pop only: count 0.
  - count 1, push and pop together: new beat goes to head, count stays 1. Full throughput is 1 beat/cycle.
  - count 2, pop: tail moves to head, count 1, ready_out rises next cycle.
  - count 2 with no push: holds.
- Overflow: alu_out_valid=1 while ready_out=0:
  - the beat is discarded and no state changes;
  - err_overflow is set and stays set until reset.
- phv_out_cnt increments on each pop; wraps from all-ones to 0.
- stall_cnt increments every cycle with phv_out_valid=1 && ready_in=0; holds at all-ones.
- Reset (rst_n=0 sampled on a clk edge), including mid-operation:
  - count 0, both entries flushed;
  - phv_out 0, phv_out_valid 0, ready_out 1;
  - phv_out_cnt 0, stall_cnt 0, err_overflow 0.
  - In-flight beats are lost; the first post-reset beat behaves as in the latency rule.

Decomposition:
- Shared package rmt_phv_pkg holds:
  - container widths and counts (8 per bank);
  - PHV_LEN;
  - bank bit offsets (OFF_6B=640, OFF_4B=384, OFF_2B=256, REMAIN_W=256);
  - container-slice helper functions.
- The crossbar and this block both use the package.
- One sub-module: phv_skid_buf2, a generic 2-entry registered-ready skid buffer parameterised on data width.
- The top level does the packing, statistics and error flag.

Test Plan:
- Passthrough:
  - Stimulus: reset, then one beat with 6B all 48'h0000_0000_0007, 4B 32'hA5A5_0001, 2B 16'hBEEF, remain 256'h1, ready_in=1.
  - Required: phv_out_valid at cycle N+1; phv_out[1023:976]=48'h7, phv_out[383:368]=16'hBEEF, phv_out[255:0]=1; phv_out_cnt=1.
- Backpressure fill:
  - Stimulus: ready_in=0, push beats A then B.
  - Required: ready_out=0 from the cycle after B; phv_out=A held; stall_cnt counts each held cycle.
  - Then raise ready_in: A then B emitted in order, ready_out=1 one cycle after A pops.
- Streaming:
  - Stimulus: 100 back-to-back beats with an incrementing remain tag, ready_in=1.
  - Required: 100 outputs on consecutive cycles, in order, no gaps; phv_out_cnt=100.
- Overflow:
  - Stimulus: with count=2, assert alu_out_valid with tag 0xDEAD.
  - Required: err_overflow=1 and sticky; 0xDEAD never appears on phv_out; count unchanged.
- Reset mid-operation:
  - Stimulus: count=2, stall_cnt=5, then rst_n=0 for 1 clk.
  - Required: next cycle phv_out_valid=0, ready_out=1, all counters 0; the next push emerges 1 cycle later.
- Counter limits:
  - Stimulus: force phv_out_cnt and stall_cnt to all-ones, then one pop and one stall cycle.
  - Required: phv_out_cnt=0, stall_cnt stays all-ones.
